// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared types for the multi-cycle multiply/divide unit. The instruction
// decoder imports this package to turn funct fields into muldiv_op_t, so
// the encoding below is architectural and must not be reordered.
//   muldiv_op_t    : operation issued from execute
//   muldiv_state_t : state encoding of the unit's sequencer
// -----------------------------------------------------------------------------
package muldiv_pkg;

   typedef enum logic [2:0] {
      NONE  = 3'd0,
      MULT  = 3'd1,
      MULTU = 3'd2,
      DIV   = 3'd3,
      DIVU  = 3'd4,
      MTHI  = 3'd5,
      MTLO  = 3'd6
   } muldiv_op_t;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      COMMIT
   } muldiv_state_t;

   // Signed ops work on magnitudes and fix the sign up at the end.
   function automatic logic is_signed_op(muldiv_op_t op);
      return (op == MULT) || (op == DIV);
   endfunction

   function automatic logic is_mul_op(muldiv_op_t op);
      return (op == MULT) || (op == MULTU);
   endfunction

   function automatic logic is_div_op(muldiv_op_t op);
      return (op == DIV) || (op == DIVU);
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if
// Bundle between the execute stage (master) and the multiply/divide unit
// (slave).
//   start_execute  : issue strobe
//   op_execute     : operation to perform
//   src_a_execute  : forwarded rs (multiplicand / dividend / MTHI-MTLO data)
//   src_b_execute  : forwarded rt (multiplier / divisor)
//   flush_muldiv   : abort any in-flight op
//   busy, done     : status back to the hazard unit
//   hi, lo         : architectural HI/LO registers
// -----------------------------------------------------------------------------
interface muldiv_if
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
);

   logic             start_execute;
   muldiv_op_t       op_execute;
   logic [WIDTH-1:0] src_a_execute;
   logic [WIDTH-1:0] src_b_execute;
   logic             flush_muldiv;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start_execute, op_execute, src_a_execute, src_b_execute, flush_muldiv,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start_execute, op_execute, src_a_execute, src_b_execute, flush_muldiv,
      output busy, done, hi, lo
   );

endinterface

// File: rtl/muldiv_iter.sv
// -----------------------------------------------------------------------------
// muldiv_iter
// One combinational radix-2 step of either a shift-add multiply or a
// restoring shift-subtract divide, selected by mode_div. WIDTH must be >= 2.
//   mode_div : 0 = multiply step, 1 = divide step
//   acc_in   : 2*WIDTH working accumulator before the step
//   operand  : multiplicand magnitude (mul) or divisor magnitude (div)
//   acc_out  : accumulator after the step
// Multiply layout: acc = {partial product high half, remaining multiplier};
// the multiplier shifts out of the bottom while the product shifts in.
// Divide layout: acc = {partial remainder, remaining dividend / quotient};
// dividend bits shift out of the top of the low half, quotient bits in.
// -----------------------------------------------------------------------------
module muldiv_iter #(
   parameter int WIDTH = 32
) (
   input  logic                 mode_div,
   input  logic [2*WIDTH-1:0]   acc_in,
   input  logic [WIDTH-1:0]     operand,
   output logic [2*WIDTH-1:0]   acc_out
);

   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_upper;
   logic [WIDTH:0]     div_trial;
   logic [2*WIDTH-1:0] mul_next;
   logic [2*WIDTH-1:0] div_next;

   // The multiply sum keeps its carry bit so the right shift folds it back
   // into the top of the accumulator. For divide, the shifted remainder can
   // reach WIDTH+1 bits, so the trial subtract is done one bit wider and its
   // top bit tells whether the subtraction must be restored.
   always_comb begin
      mul_sum   = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
      mul_next  = {mul_sum, acc_in[WIDTH-1:1]};

      div_upper = acc_in[2*WIDTH-1:WIDTH-1];
      div_trial = div_upper - {1'b0, operand};
      if (!div_trial[WIDTH]) begin
         div_next = {div_trial[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b1};
      end else begin
         div_next = {div_upper[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
      end

      acc_out = mode_div ? div_next : mul_next;
   end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Multi-cycle integer multiply/divide unit with architectural HI/LO.
// MULT/MULTU/DIV/DIVU take WIDTH+1 busy cycles (WIDTH iterations + commit);
// MTHI/MTLO write in a single cycle without raising busy.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low; clears all state
//   bus    : muldiv_if slave (issue, flush, busy/done, hi/lo)
// Parameters:
//   WIDTH      : operand width (>= 2); product is 2*WIDTH
//   ENABLE_DIV : 0 turns DIV/DIVU into no-ops
// -----------------------------------------------------------------------------
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter bit ENABLE_DIV = 1'b1
) (
   input  logic     clk,
   input  logic     reset,
   muldiv_if.slave  bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

   muldiv_state_t      state;
   logic [CW-1:0]      count;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   operand;
   logic               mode_div;
   logic               neg_main;
   logic               neg_rem;
   logic               div_zero;
   logic [WIDTH-1:0]   src_a_saved;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               busy_q;
   logic               done_q;

   logic               signed_op;
   logic [2*WIDTH-1:0] a_ext;
   logic [2*WIDTH-1:0] b_ext;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic               accept;
   logic               launch_mul;
   logic               launch_div;

   logic [2*WIDTH-1:0] product_fix;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   commit_hi;
   logic [WIDTH-1:0]   commit_lo;

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hi   = hi_q;
   assign bus.lo   = lo_q;

   muldiv_iter #(.WIDTH(WIDTH)) u_iter (
      .mode_div (mode_div),
      .acc_in   (acc),
      .operand  (operand),
      .acc_out  (acc_next)
   );

   // Operand magnitudes are taken in 2*WIDTH arithmetic so that the most
   // negative value maps cleanly onto its unsigned magnitude 2^(WIDTH-1).
   // A flush in the same idle cycle drops the issue, MTHI/MTLO included.
   always_comb begin
      signed_op  = is_signed_op(bus.op_execute);
      a_ext      = signed_op ? {{WIDTH{bus.src_a_execute[WIDTH-1]}}, bus.src_a_execute}
                             : {{WIDTH{1'b0}}, bus.src_a_execute};
      b_ext      = signed_op ? {{WIDTH{bus.src_b_execute[WIDTH-1]}}, bus.src_b_execute}
                             : {{WIDTH{1'b0}}, bus.src_b_execute};
      a_neg      = a_ext[2*WIDTH-1];
      b_neg      = b_ext[2*WIDTH-1];
      a_mag      = WIDTH'(a_neg ? -a_ext : a_ext);
      b_mag      = WIDTH'(b_neg ? -b_ext : b_ext);
      accept     = (state == IDLE) && bus.start_execute && !bus.flush_muldiv;
      launch_mul = accept && is_mul_op(bus.op_execute);
      launch_div = accept && is_div_op(bus.op_execute) && ENABLE_DIV;
   end

   // Sign fixup applied in the commit cycle. A zero divisor overrides the
   // iterated result: quotient all ones and remainder equal to the dividend
   // exactly as issued, regardless of signedness.
   always_comb begin
      product_fix = neg_main ? -acc : acc;
      quot        = acc[WIDTH-1:0];
      rem         = acc[2*WIDTH-1:WIDTH];
      if (mode_div) begin
         commit_lo = div_zero ? '1 : (neg_main ? -quot : quot);
         commit_hi = div_zero ? src_a_saved : (neg_rem ? -rem : rem);
      end else begin
         commit_hi = product_fix[2*WIDTH-1:WIDTH];
         commit_lo = product_fix[WIDTH-1:0];
      end
   end

   // Sequencer IDLE -> CALC -> COMMIT -> IDLE. busy/done are registered
   // alongside the state so they always match (busy = not idle, done = in
   // commit). The counter holds at WIDTH-1 rather than wrapping; the exit
   // is decoded from that value. Flush returns to IDLE without touching
   // HI/LO, so an aborted op leaves the pre-op values visible.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         count       <= '0;
         acc         <= '0;
         operand     <= '0;
         mode_div    <= 1'b0;
         neg_main    <= 1'b0;
         neg_rem     <= 1'b0;
         div_zero    <= 1'b0;
         src_a_saved <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (launch_mul || launch_div) begin
                  state       <= CALC;
                  busy_q      <= 1'b1;
                  count       <= '0;
                  mode_div    <= launch_div;
                  acc         <= launch_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                  operand     <= launch_div ? b_mag : a_mag;
                  neg_main    <= a_neg ^ b_neg;
                  neg_rem     <= a_neg;
                  div_zero    <= launch_div && (bus.src_b_execute == '0);
                  src_a_saved <= bus.src_a_execute;
               end else if (accept && (bus.op_execute == MTHI)) begin
                  hi_q <= bus.src_a_execute;
               end else if (accept && (bus.op_execute == MTLO)) begin
                  lo_q <= bus.src_a_execute;
               end
            end
            CALC: begin
               if (bus.flush_muldiv) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
                  done_q <= 1'b0;
               end else begin
                  acc <= acc_next;
                  if (count == LAST_COUNT) begin
                     state  <= COMMIT;
                     done_q <= 1'b1;
                  end else begin
                     count <= count + 1'b1;
                  end
               end
            end
            COMMIT: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
               if (!bus.flush_muldiv) begin
                  hi_q <= commit_hi;
                  lo_q <= commit_lo;
               end
            end
            default: begin
               state  <= IDLE;
               busy_q <= 1'b0;
               done_q <= 1'b0;
            end
         endcase
      end
   end

   // The hazard unit should never issue into a busy unit; the issue is
   // ignored in hardware, but flag it in simulation.
   always @(posedge clk) begin
      if (reset) begin
         assert (!(bus.start_execute && busy_q))
            else $warning("[muldiv_unit] start_execute while busy is ignored");
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Self-checking bench for muldiv_unit at WIDTH=32: a table of directed
// arithmetic vectors followed by hand-written flush, MTHI/MTLO and reset
// sequences. Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
   import muldiv_pkg::*;

   typedef struct {
      string      name;
      muldiv_op_t op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   busy_cycles;
   int   done_cycles;
   vec_t vecs[12];

   muldiv_if #(.WIDTH(32)) bus ();

   muldiv_unit #(.WIDTH(32), .ENABLE_DIV(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Global time limit so a stuck design still ends the run
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] time limit");
   end

   // Compare one value and record the outcome
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Drive one cycle of inputs starting at a falling edge, return to idle inputs
   task automatic driveCycle(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b, input logic flush);
      bus.start_execute = (op != NONE);
      bus.op_execute    = op;
      bus.src_a_execute = a;
      bus.src_b_execute = b;
      bus.flush_muldiv  = flush;
      @(negedge clk);
      bus.start_execute = 1'b0;
      bus.op_execute    = NONE;
      bus.src_a_execute = '0;
      bus.src_b_execute = '0;
      bus.flush_muldiv  = 1'b0;
   endtask

   // Issue a full arithmetic op and count busy and done cycles until idle
   task automatic applyStimulus(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                                output int nbusy, output int ndone);
      nbusy = 0;
      ndone = 0;
      driveCycle(op, a, b, 1'b0);
      for (int i = 0; i < 100 && bus.busy; i++) begin
         nbusy++;
         if (bus.done) ndone++;
         @(negedge clk);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;

      vecs[0]  = '{"mult_neg2x3",     MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA};
      vecs[1]  = '{"multu_big_x3",    MULTU, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA};
      vecs[2]  = '{"divu_100_7",      DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
      vecs[3]  = '{"div_neg7_2",      DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[4]  = '{"div_5_0",         DIV,   32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
      vecs[5]  = '{"div_min_neg1",    DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
      vecs[6]  = '{"mult_7_neg3",     MULT,  32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
      vecs[7]  = '{"multu_max_max",   MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      vecs[8]  = '{"div_neg7_neg2",   DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3};
      vecs[9]  = '{"div_7_neg2",      DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
      vecs[10] = '{"divu_big_2",      DIVU,  32'hFFFF_FFF9, 32'd2,         32'd1,         32'h7FFF_FFFC};
      vecs[11] = '{"divu_neg_by_0",   DIVU,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF};

      reset             = 1'b0;
      bus.start_execute = 1'b0;
      bus.op_execute    = NONE;
      bus.src_a_execute = '0;
      bus.src_b_execute = '0;
      bus.flush_muldiv  = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("reset_busy", 64'(bus.busy), 64'd0);
      checkOutput("reset_done", 64'(bus.done), 64'd0);
      checkOutput("reset_hi",   64'(bus.hi),   64'd0);
      checkOutput("reset_lo",   64'(bus.lo),   64'd0);
      reset = 1'b1;
      @(negedge clk);

      // Table-driven arithmetic vectors
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, busy_cycles, done_cycles);
         checkOutput({vecs[i].name, "_busy_cycles"}, 64'(busy_cycles), 64'd33);
         checkOutput({vecs[i].name, "_done_pulses"}, 64'(done_cycles), 64'd1);
         checkOutput({vecs[i].name, "_hi"}, 64'(bus.hi), 64'(vecs[i].exp_hi));
         checkOutput({vecs[i].name, "_lo"}, 64'(bus.lo), 64'(vecs[i].exp_lo));
      end

      // Preload, then flush a MULTU in its tenth busy cycle
      driveCycle(MTHI, 32'hA, 32'd0, 1'b0);
      checkOutput("preload_hi", 64'(bus.hi), 64'hA);
      checkOutput("preload_busy", 64'(bus.busy), 64'd0);
      driveCycle(MTLO, 32'hB, 32'd0, 1'b0);
      checkOutput("preload_lo", 64'(bus.lo), 64'hB);
      checkOutput("preload_hi_kept", 64'(bus.hi), 64'hA);
      driveCycle(MULTU, 32'h0001_2345, 32'h0000_0777, 1'b0);
      checkOutput("flush_busy_before", 64'(bus.busy), 64'd1);
      done_cycles = 0;
      for (int i = 0; i < 9; i++) begin
         if (bus.done) done_cycles++;
         @(negedge clk);
      end
      driveCycle(NONE, 32'd0, 32'd0, 1'b1);
      checkOutput("flush_busy_after", 64'(bus.busy), 64'd0);
      checkOutput("flush_done_after", 64'(bus.done), 64'd0);
      checkOutput("flush_hi", 64'(bus.hi), 64'hA);
      checkOutput("flush_lo", 64'(bus.lo), 64'hB);
      @(negedge clk);
      checkOutput("flush_no_late_done", 64'(bus.done) + 64'(done_cycles), 64'd0);
      applyStimulus(MULT, 32'hFFFF_FFFC, 32'd5, busy_cycles, done_cycles);
      checkOutput("post_flush_busy_cycles", 64'(busy_cycles), 64'd33);
      checkOutput("post_flush_done_pulses", 64'(done_cycles), 64'd1);
      checkOutput("post_flush_hi", 64'(bus.hi), 64'hFFFF_FFFF);
      checkOutput("post_flush_lo", 64'(bus.lo), 64'hFFFF_FFEC);

      // MTHI while idle, MTLO while busy, flush with MTLO, op NONE
      driveCycle(MTHI, 32'h1234, 32'd0, 1'b0);
      checkOutput("mthi_hi", 64'(bus.hi), 64'h1234);
      checkOutput("mthi_lo_kept", 64'(bus.lo), 64'hFFFF_FFEC);
      checkOutput("mthi_busy", 64'(bus.busy), 64'd0);
      checkOutput("mthi_done", 64'(bus.done), 64'd0);
      driveCycle(MULT, 32'd2, 32'd3, 1'b0);
      driveCycle(MTLO, 32'hDEAD, 32'd0, 1'b0);
      checkOutput("mtlo_busy_lo", 64'(bus.lo), 64'hFFFF_FFEC);
      checkOutput("mtlo_busy_still", 64'(bus.busy), 64'd1);
      busy_cycles = 1;
      for (int i = 0; i < 100 && bus.busy; i++) begin
         busy_cycles++;
         @(negedge clk);
      end
      checkOutput("mtlo_busy_cycles", 64'(busy_cycles), 64'd33);
      checkOutput("mtlo_busy_hi", 64'(bus.hi), 64'd0);
      checkOutput("mtlo_busy_result_lo", 64'(bus.lo), 64'd6);
      driveCycle(MTLO, 32'hBEEF, 32'd0, 1'b1);
      checkOutput("flush_mtlo_lo", 64'(bus.lo), 64'd6);
      checkOutput("flush_mtlo_busy", 64'(bus.busy), 64'd0);
      driveCycle(NONE, 32'h99, 32'd1, 1'b0);
      checkOutput("none_busy", 64'(bus.busy), 64'd0);
      checkOutput("none_lo", 64'(bus.lo), 64'd6);

      // Reset in the twentieth busy cycle of a DIV, then a clean DIVU
      driveCycle(MTHI, 32'h55, 32'd0, 1'b0);
      driveCycle(DIV, 32'd100, 32'd3, 1'b0);
      repeat (19) @(negedge clk);
      checkOutput("prereset_busy", 64'(bus.busy), 64'd1);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("midop_reset_hi",   64'(bus.hi),   64'd0);
      checkOutput("midop_reset_lo",   64'(bus.lo),   64'd0);
      checkOutput("midop_reset_busy", 64'(bus.busy), 64'd0);
      checkOutput("midop_reset_done", 64'(bus.done), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("after_release_busy", 64'(bus.busy), 64'd0);
      applyStimulus(DIVU, 32'd9, 32'd3, busy_cycles, done_cycles);
      checkOutput("divu_9_3_busy_cycles", 64'(busy_cycles), 64'd33);
      checkOutput("divu_9_3_done_pulses", 64'(done_cycles), 64'd1);
      checkOutput("divu_9_3_lo", 64'(bus.lo), 64'd3);
      checkOutput("divu_9_3_hi", 64'(bus.hi), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
